// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback, NZCV flags, condition check.
// Latency: DP 4, LDR 5, STR 4, B 3, condition-failed 2 cycles; outputs are combinational from state.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready; each low cycle adds one cycle.
module multicycle_control_fsm #(
  parameter int ADDR_INC = 4,
  parameter logic [3:0] REG_NUM_PC = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       adr_src,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl,
  output logic [1:0] imm_src,
  output logic [3:0] flags,
  output logic       instr_done,
  output logic [3:0] state_dbg
);

  // The PC increment constant lives in the datapath; only the value 4 matches alu_src_b=10.
  if (ADDR_INC != 4) begin : g_bad_inc
    $error("multicycle_control_fsm: datapath increment must be 4");
  end

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADR   = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic [1:0] alu_dec;
  logic       cmd_ok;
  logic       in_exec;
  logic       to_pc;

  logic n_f, z_f, c_f, v_f, ge;
  assign {n_f, z_f, c_f, v_f} = flags_q;
  assign ge      = (n_f == v_f);
  assign in_exec = (state == S_EXEC_R) || (state == S_EXEC_I);
  assign to_pc   = (rd == REG_NUM_PC);

  // Condition check against the stored flags
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~(c_f & ~z_f);
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~z_f & ge;
      4'b1101: cond_ex = ~(~z_f & ge);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Data-processing command decode; unknown commands become a NOP (ADD, no writeback, no flags)
  always_comb begin
    alu_dec = ALU_ADD;
    cmd_ok  = 1'b1;
    case (funct[4:1])
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      default: cmd_ok  = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Flag register: ADD/SUB write NZCV, logical ops write NZ and keep C and V
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (in_exec && funct[0] && cmd_ok) begin
      if (alu_dec == ALU_ADD || alu_dec == ALU_SUB) flags_q <= alu_flags;
      else                                          flags_q <= {alu_flags[3:2], flags_q[1:0]};
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!cond_ex || op == 2'b11) state_nxt = S_FETCH;
        else if (op == 2'b00)        state_nxt = funct[5] ? S_EXEC_I : S_EXEC_R;
        else if (op == 2'b01)        state_nxt = S_MEM_ADR;
        else                         state_nxt = S_BRANCH;
      end
      S_EXEC_R,
      S_EXEC_I:    state_nxt = S_ALU_WB;
      S_ALU_WB:    state_nxt = S_FETCH;
      S_MEM_ADR:   state_nxt = funct[0] ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // Output decode; reset forces FETCH values with every write enable held low
  always_comb begin
    pc_we      = 1'b0;
    adr_src    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    case (rst ? S_FETCH : state)
      S_FETCH: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_we      = mem_ready;
        pc_we      = mem_ready;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        instr_done = !cond_ex || op == 2'b11;
      end
      S_EXEC_R: alu_ctrl = alu_dec;
      S_EXEC_I: begin
        alu_src_b = 2'b01;
        alu_ctrl  = alu_dec;
      end
      S_ALU_WB: begin
        pc_we      = cmd_ok & to_pc;
        reg_we     = cmd_ok & ~to_pc;
        instr_done = 1'b1;
      end
      S_MEM_ADR:  alu_src_b = 2'b01;
      S_MEM_READ: adr_src   = 1'b1;
      S_MEM_WB: begin
        result_src = 2'b01;
        pc_we      = to_pc;
        reg_we     = ~to_pc;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src    = 1'b1;
        mem_we     = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign imm_src   = op;
  assign flags     = flags_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle trace of every output built from the instruction rules.
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       pc_we, adr_src, mem_we, ir_we, reg_we, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src;
  logic [3:0] flags, state_dbg;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .pc_we(pc_we), .adr_src(adr_src),
    .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
    .flags(flags), .instr_done(instr_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] ref_flags;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       pc, ir, mw, rw, done, adr;
    logic [1:0] rs, a, b, ctrl;
  } cyc_t;

  cyc_t q[$];

  function automatic cyc_t mk(input logic [3:0] st, input logic mr);
    cyc_t c;
    c = '0;
    c.st = st;
    c.mr = mr;
    return c;
  endfunction

  // Condition codes evaluated from named flag bits: even codes test, odd codes negate
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, ge, base;
    {n, z, cy, v} = f;
    ge = (n == v);
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = ge;
      3'd6: base = !z && ge;
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of the trace and compare every control output
  task automatic step(input cyc_t e, input logic [3:0] af);
    logic [19:0] obs, exp;
    @(negedge clk);
    mem_ready = e.mr;
    alu_flags = (e.st == 4'd2 || e.st == 4'd3) ? af : 4'($urandom);
    #1;
    obs = {state_dbg, pc_we, ir_we, mem_we, reg_we, instr_done, adr_src,
           result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src};
    exp = {e.st, e.pc, e.ir, e.mw, e.rw, e.done, e.adr, e.rs, e.a, e.b, e.ctrl, op};
    check($sformatf("cycle st%0d", e.st), 32'(obs), 32'(exp));
  endtask

  // Expected per-cycle trace of one instruction, from the instruction class rules
  task automatic build(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input int fw, input int mw,
                       output bit pass, output bit sup, output logic [1:0] ctrl);
    cyc_t e;
    bit redirect;
    redirect = (r == 4'd15);
    sup = 1'b0;
    ctrl = 2'b00;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      e = mk(4'd0, 1'(i == fw));
      e.a = 2'b01; e.b = 2'b10; e.rs = 2'b10; e.pc = e.mr; e.ir = e.mr;
      q.push_back(e);
    end
    pass = cond_pass(c, ref_flags);
    e = mk(4'd1, 1'($urandom));
    e.a = 2'b01; e.b = 2'b10; e.done = (!pass || o == 2'b11);
    q.push_back(e);
    if (e.done) return;
    case (o)
      2'b00: begin
        sup = 1'b1;
        case (f[4:1])
          4'b0100: ctrl = 2'b00;
          4'b0010: ctrl = 2'b01;
          4'b0000: ctrl = 2'b10;
          4'b1100: ctrl = 2'b11;
          default: sup = 1'b0;
        endcase
        e = mk(f[5] ? 4'd3 : 4'd2, 1'($urandom));
        e.b = f[5] ? 2'b01 : 2'b00; e.ctrl = ctrl;
        q.push_back(e);
        e = mk(4'd4, 1'($urandom));
        e.done = 1'b1;
        if (sup) begin e.pc = redirect; e.rw = !redirect; end
        q.push_back(e);
      end
      2'b01: begin
        e = mk(4'd5, 1'($urandom));
        e.b = 2'b01;
        q.push_back(e);
        if (f[0]) begin
          for (int i = 0; i <= mw; i++) begin
            e = mk(4'd6, 1'(i == mw));
            e.adr = 1'b1;
            q.push_back(e);
          end
          e = mk(4'd7, 1'($urandom));
          e.rs = 2'b01; e.done = 1'b1; e.pc = redirect; e.rw = !redirect;
          q.push_back(e);
        end else begin
          for (int i = 0; i <= mw; i++) begin
            e = mk(4'd8, 1'(i == mw));
            e.adr = 1'b1; e.mw = 1'b1; e.done = e.mr;
            q.push_back(e);
          end
        end
      end
      default: begin
        e = mk(4'd9, 1'($urandom));
        e.a = 2'b10; e.b = 2'b01; e.rs = 2'b10; e.pc = 1'b1; e.done = 1'b1;
        q.push_back(e);
      end
    endcase
  endtask

  task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                     input logic [3:0] r, input int fw, input int mw, input logic [3:0] af);
    bit pass, sup;
    logic [1:0] ctrl;
    int ncyc;
    cond = c; op = o; funct = f; rd = r;
    build(c, o, f, r, fw, mw, pass, sup, ctrl);
    ncyc = q.size();
    foreach (q[i]) step(q[i], af);
    if (pass && o == 2'b00 && f[0] && sup) begin
      if (ctrl <= 2'b01) ref_flags = af;
      else               ref_flags = {af[3:2], ref_flags[1:0]};
    end
    @(posedge clk);
    #1;
    check($sformatf("flags after %0d-cycle instr", ncyc), 32'(flags), 32'(ref_flags));
    check("back in fetch", 32'(state_dbg), 32'd0);
  endtask

  logic [3:0] cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};

  initial begin
    cyc_t e;
    bit pass, sup;
    logic [1:0] ctrl;
    logic [5:0] f;
    rst = 1'b1; cond = 4'hE; op = 2'b00; funct = '0; rd = '0;
    alu_flags = '0; mem_ready = 1'b1; ref_flags = 4'b0000;

    // Reset: FETCH values, write enables suppressed even with mem_ready high
    repeat (2) @(posedge clk);
    e = mk(4'd0, 1'b1);
    e.a = 2'b01; e.b = 2'b10; e.rs = 2'b10;
    step(e, 4'h0);
    check("reset flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADDS immediate, rd=2: 4 cycles, reg_we in writeback, flags from ALU
    run(4'hE, 2'b00, 6'b101001, 4'd2, 0, 0, 4'b0110);
    check("ADDS flags", 32'(flags), 32'h6);
    // ORRS with flags preset 0011: C and V retained
    run(4'hE, 2'b00, 6'b101001, 4'd3, 0, 0, 4'b0011);
    run(4'hE, 2'b00, 6'b011001, 4'd4, 0, 0, 4'b1000);
    check("ORRS flags", 32'(flags), 32'hB);
    // BEQ with Z=0 is skipped, then taken after Z is set
    run(4'h0, 2'b10, 6'b000000, 4'd0, 0, 0, 4'h0);
    run(4'hE, 2'b00, 6'b101001, 4'd1, 0, 0, 4'b0100);
    run(4'h0, 2'b10, 6'b000000, 4'd0, 0, 0, 4'h0);
    // LDR into PC with two wait states; STR with three
    run(4'hE, 2'b01, 6'b011001, 4'd15, 0, 2, 4'h0);
    run(4'hE, 2'b01, 6'b011000, 4'd5, 1, 3, 4'h0);
    // Unsupported command and unsupported op
    run(4'hE, 2'b00, 6'b011111, 4'd6, 0, 0, 4'hF);
    run(4'hE, 2'b11, 6'b000000, 4'd6, 0, 0, 4'hF);

    // Reset in the middle of a store: mem_we drops at once, flags clear on the edge
    run(4'hE, 2'b00, 6'b101001, 4'd1, 0, 0, 4'b1111);
    cond = 4'hE; op = 2'b01; funct = 6'b000000; rd = 4'd3;
    build(4'hE, 2'b01, 6'b000000, 4'd3, 0, 5, pass, sup, ctrl);
    foreach (q[i]) begin
      step(q[i], 4'h0);
      if (q[i].st == 4'd8) break;
    end
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst outputs", 32'({state_dbg, pc_we, ir_we, instr_done, adr_src, result_src, alu_src_a, alu_src_b}),
          32'({4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10}));
    @(posedge clk);
    #1;
    check("rst state", 32'(state_dbg), 32'd0);
    check("rst flags", 32'(flags), 32'd0);
    rst = 1'b0;
    ref_flags = 4'b0000;

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      f = 6'($urandom);
      if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 3)];
      run(4'($urandom), 2'($urandom), f,
          ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
          $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
